// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - state encoding and sizing constants for the program loader
package prog_loader_pkg;

  localparam int PROG_DEPTH = 1024;
  localparam int PROG_DW    = 18;
  localparam int PROG_AW    = 10;
  localparam int WORD_BYTES = 3;

  typedef enum logic [3:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    B0,
    B1,
    B2,
    WRITE,
    CK,
    FINISH,
    ERROR
  } state_t;

endpackage

// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - byte stream in, program RAM write port and session status out
interface prog_loader_if #(
  parameter int ADDR_W = prog_loader_pkg::PROG_AW,
  parameter int DATA_W = prog_loader_pkg::PROG_DW
);

  logic              START;
  logic [7:0]        BYTE_IN;
  logic              BYTE_VALID;
  logic              BYTE_READY;
  logic              WR_EN;
  logic [ADDR_W-1:0] WR_ADDR;
  logic [DATA_W-1:0] WR_DATA;
  logic              MCU_HOLD;
  logic              BUSY;
  logic              DONE;
  logic              ERR;

  modport master (
    output START, BYTE_IN, BYTE_VALID,
    input  BYTE_READY, WR_EN, WR_ADDR, WR_DATA, MCU_HOLD, BUSY, DONE, ERR
  );

  modport slave (
    input  START, BYTE_IN, BYTE_VALID,
    output BYTE_READY, WR_EN, WR_ADDR, WR_DATA, MCU_HOLD, BUSY, DONE, ERR
  );

endinterface

// File: rtl/prog_word_packer.sv
// rtl/prog_word_packer.sv - assembles three stream bytes into one 18-bit instruction word
module prog_word_packer
  import prog_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         byte_in,
  input  logic               take_b0,
  input  logic               take_b1,
  input  logic               take_b2,
  output logic               b0_bad,
  output logic [PROG_DW-1:0] word
);

  // Bits held back until the final byte of the word arrives.
  localparam int STAGE_W = PROG_DW - 8 * (WORD_BYTES - 2);

  logic [STAGE_W-1:0] stage_q;
  logic [PROG_DW-1:0] word_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
      word_q  <= '0;
    end else begin
      if (take_b0) stage_q[STAGE_W-1:8] <= byte_in[1:0];
      if (take_b1) stage_q[7:0]         <= byte_in;
      if (take_b2) word_q               <= {stage_q, byte_in};
    end
  end

  assign b0_bad = |byte_in[7:2];
  assign word   = word_q;

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream loader that writes the RAT program RAM and holds the MCU in reset
// PROG_LOADER_CKSUM_EN adds a trailing XOR checksum byte checked before DONE.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = PROG_AW,
  parameter int DEPTH  = PROG_DEPTH,
  parameter int DATA_W = PROG_DW
) (
  input  logic         PROG_CLK,
  input  logic         PROG_RST,
  prog_loader_if.slave bus
);

  localparam int              HI_W    = ADDR_W + 1 - 8;
  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W + 1)'(DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   len_rx;
  logic [HI_W-1:0]   len_hi_q;
  logic              err_q;
  logic              byte_ready;
  logic              xfer;
  logic              last_word;
  logic              b0_bad;
  logic [DATA_W-1:0] word;

  assign byte_ready = state_q inside {HDR_HI, HDR_LO, B0, B1, B2, CK};
  assign xfer       = bus.BYTE_VALID && byte_ready;
  assign len_rx     = {len_hi_q, bus.BYTE_IN};
  assign last_word  = ({1'b0, idx_q} + (ADDR_W + 1)'(1)) == len_q;

  prog_word_packer u_packer (
    .clk     (PROG_CLK),
    .rst     (PROG_RST),
    .byte_in (bus.BYTE_IN),
    .take_b0 (xfer && state_q == B0),
    .take_b1 (xfer && state_q == B1),
    .take_b2 (xfer && state_q == B2),
    .b0_bad  (b0_bad),
    .word    (word)
  );

`ifdef PROG_LOADER_CKSUM_EN
  logic [7:0] cksum_q;

  always_ff @(posedge PROG_CLK) begin
    if (PROG_RST) begin
      cksum_q <= '0;
    end else if (state_q == IDLE && bus.START) begin
      cksum_q <= '0;
    end else if (xfer && state_q != CK) begin
      cksum_q <= cksum_q ^ bus.BYTE_IN;
    end
  end
`endif

  always_ff @(posedge PROG_CLK) begin
    if (PROG_RST) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      len_q    <= '0;
      len_hi_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.START) begin
        idx_q <= '0;
        len_q <= '0;
        err_q <= 1'b0;
      end
      if (state_q == HDR_HI && xfer) len_hi_q <= bus.BYTE_IN[HI_W-1:0];
      if (state_q == HDR_LO && xfer) len_q    <= len_rx;
      // The final index is kept so WR_ADDR keeps showing the last word written.
      if (state_q == WRITE && !last_word) idx_q <= idx_q + ADDR_W'(1);
      if (state_d == ERROR) err_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (bus.START) state_d = HDR_HI;
      HDR_HI: if (xfer) state_d = HDR_LO;
      HDR_LO: if (xfer) state_d = (len_rx == '0 || len_rx > MAX_LEN) ? ERROR : B0;
      B0:     if (xfer) state_d = b0_bad ? ERROR : B1;
      B1:     if (xfer) state_d = B2;
      B2:     if (xfer) state_d = WRITE;
`ifdef PROG_LOADER_CKSUM_EN
      WRITE:  state_d = last_word ? CK : B0;
      CK:     if (xfer) state_d = (bus.BYTE_IN == cksum_q) ? FINISH : ERROR;
`else
      WRITE:  state_d = last_word ? FINISH : B0;
`endif
      FINISH: state_d = IDLE;
      ERROR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.BYTE_READY = byte_ready;
  assign bus.WR_EN      = (state_q == WRITE) && !PROG_RST;
  assign bus.WR_ADDR    = idx_q;
  assign bus.WR_DATA    = word;
  assign bus.MCU_HOLD   = !(state_q inside {IDLE, FINISH, ERROR});
  assign bus.BUSY       = state_q != IDLE;
  assign bus.DONE       = state_q == FINISH;
  assign bus.ERR        = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - randomized session bench for prog_loader with a frame-level reference model
module tb_prog_loader;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int addr;
    int data;
  } wr_t;
  typedef wr_t wq_t[$];

  localparam int BUDGET = 20000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prog_loader_if bus ();

  prog_loader dut (
    .PROG_CLK (clk),
    .PROG_RST (rst),
    .bus      (bus)
  );

  int  checks = 0;
  int  errors = 0;
  wq_t wr_q;
  int  done_cnt = 0;
  int  ncyc = 0;
  int  last_wr_cyc = 0;
  int  done_cyc = 0;
  int  hold_bad = 0;

  always @(negedge clk) begin
    ncyc++;
    if (bus.WR_EN === 1'b1) begin
      wr_q.push_back('{int'(bus.WR_ADDR), int'(bus.WR_DATA)});
      last_wr_cyc = ncyc;
      if (bus.MCU_HOLD !== 1'b1) hold_bad++;
    end
    if (bus.DONE === 1'b1) begin
      done_cnt++;
      done_cyc = ncyc;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Frame-level reference: parse the byte list into the writes and outcome a loader must produce.
  function automatic void model(input bq_t b, output wq_t w, output bit done, output bit err);
    int n;
    int p;
    logic [7:0] x;
    w = {};
    done = 1'b0;
    err = 1'b0;
    n = (int'(b[0]) * 256 + int'(b[1])) % 2048;
    if (n == 0 || n > 1024) begin
      err = 1'b1;
      return;
    end
    x = b[0] ^ b[1];
    for (int k = 0; k < n; k++) begin
      p = 2 + 3 * k;
      if (b[p] > 8'd3) begin
        err = 1'b1;
        return;
      end
      w.push_back('{k, int'(b[p]) * 65536 + int'(b[p+1]) * 256 + int'(b[p+2])});
      x = x ^ b[p] ^ b[p+1] ^ b[p+2];
    end
`ifdef PROG_LOADER_CKSUM_EN
    if (b[2 + 3 * n] == x) done = 1'b1;
    else err = 1'b1;
`else
    done = 1'b1;
`endif
  endfunction

  function automatic bq_t with_ck(input bq_t b);
`ifdef PROG_LOADER_CKSUM_EN
    logic [7:0] x = 8'h00;
    foreach (b[i]) x ^= b[i];
    b.push_back(x);
`endif
    return b;
  endfunction

  function automatic bq_t build(input int n, input int bad_pct);
    bq_t b;
    b.push_back(8'((n >> 8) | ($urandom_range(31) << 3)));
    b.push_back(8'(n));
    for (int k = 0; k < n; k++) begin
      b.push_back(($urandom_range(99) < bad_pct) ? 8'($urandom_range(255, 4)) : 8'($urandom_range(3)));
      b.push_back(8'($urandom));
      b.push_back(8'($urandom));
    end
    return with_ck(b);
  endfunction

  task automatic send_stream(input bq_t b, input int gap_pct, input int stop_writes);
    int i = 0;
    int cyc = 0;
    while (i < b.size() && cyc < BUDGET) begin
      bus.START = 1'b0;
      if (bus.BUSY !== 1'b1) break;
      if (stop_writes >= 0 && wr_q.size() >= stop_writes) break;
      if ($urandom_range(99) < gap_pct) begin
        bus.BYTE_VALID = 1'b0;
        bus.BYTE_IN    = 8'($urandom);
      end else begin
        bus.BYTE_VALID = 1'b1;
        bus.BYTE_IN    = b[i];
        if (bus.BYTE_READY === 1'b1) i++;
      end
      // A START during an active session must be ignored.
      if ($urandom_range(99) < 5) bus.START = 1'b1;
      step();
      cyc++;
    end
    bus.START      = 1'b0;
    bus.BYTE_VALID = 1'b0;
    check("stream_budget", 64'(cyc < BUDGET), 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.BUSY === 1'b1 && n < 50) begin
      step();
      n++;
    end
    check({tag, "_idle"}, bus.BUSY, 0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ctl"}, {bus.BYTE_READY, bus.WR_EN, bus.MCU_HOLD, bus.BUSY, bus.DONE, bus.ERR}, 0);
    check({tag, "_addr"}, bus.WR_ADDR, 0);
    check({tag, "_data"}, bus.WR_DATA, 0);
  endtask

  task automatic run_session(input string tag, input bq_t b, input int gap_pct);
    wq_t ew;
    bit  ed;
    bit  ee;
    int  d0;
    model(b, ew, ed, ee);
    wr_q.delete();
    hold_bad = 0;
    d0 = done_cnt;
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    check({tag, "_hold_on"}, bus.MCU_HOLD, 1);
    check({tag, "_err_clr"}, bus.ERR, 0);
    send_stream(b, gap_pct, -1);
    wait_idle(tag);
    check({tag, "_nwr"}, wr_q.size(), ew.size());
    for (int k = 0; k < ew.size() && k < wr_q.size(); k++) begin
      check($sformatf("%s_a%0d", tag, k), wr_q[k].addr, ew[k].addr);
      check($sformatf("%s_d%0d", tag, k), wr_q[k].data, ew[k].data);
    end
    check({tag, "_done"}, done_cnt - d0, int'(ed));
    check({tag, "_err"}, bus.ERR, ee);
    check({tag, "_hold_off"}, bus.MCU_HOLD, 0);
    check({tag, "_hold_wr"}, hold_bad, 0);
`ifndef PROG_LOADER_CKSUM_EN
    if (ed) check({tag, "_done_lat"}, done_cyc - last_wr_cyc, 1);
`endif
  endtask

  initial begin
    bq_t b;
    wq_t ew;
    bit  ed;
    bit  ee;

    rst            = 1'b1;
    bus.START      = 1'b0;
    bus.BYTE_VALID = 1'b0;
    bus.BYTE_IN    = 8'h00;
    repeat (3) step();
    check_quiet("reset");
    rst = 1'b0;
    step();
    check_quiet("post_reset");

    bus.BYTE_VALID = 1'b1;
    bus.BYTE_IN    = 8'h55;
    repeat (4) step();
    check("nostart_ready", bus.BYTE_READY, 0);
    check("nostart_busy", bus.BUSY, 0);
    check("nostart_nwr", wr_q.size(), 0);
    bus.BYTE_VALID = 1'b0;

    b = {8'h00, 8'h02, 8'h03, 8'hAB, 8'hCD, 8'h00, 8'h12, 8'h34};
    run_session("two", with_ck(b), 0);
    check("two_w0", (wr_q.size() > 0) ? wr_q[0].data : -1, 32'h3ABCD);
    check("two_w1", (wr_q.size() > 1) ? wr_q[1].data : -1, 32'h01234);
    check("two_a1", (wr_q.size() > 1) ? wr_q[1].addr : -1, 1);

    b = {8'h04, 8'h00};
    for (int k = 0; k < 1024; k++) begin
      b.push_back(8'h00);
      b.push_back(8'(k >> 8));
      b.push_back(8'(k));
    end
    run_session("full", with_ck(b), 0);
    check("full_last_addr", (wr_q.size() > 0) ? wr_q[$].addr : -1, 32'h3FF);
    check("full_addr_hold", bus.WR_ADDR, 10'h3FF);
    check("full_data_hold", bus.WR_DATA, 18'h003FF);

    b = {8'h00, 8'h00};
    run_session("len0", b, 0);
    check("len0_err", bus.ERR, 1);
    step();
    check("len0_err_sticky", bus.ERR, 1);
    b = {8'h04, 8'h01};
    run_session("len1025", b, 0);
    check("len1025_err", bus.ERR, 1);

    b = {8'h00, 8'h02, 8'h04, 8'h11, 8'h22, 8'h00, 8'h33, 8'h44};
    run_session("bad_b0", with_ck(b), 0);
    check("bad_b0_nwr", wr_q.size(), 0);
    check("bad_b0_err", bus.ERR, 1);

    b = build(10, 0);
    model(b, ew, ed, ee);
    wr_q.delete();
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    send_stream(b, 50, 5);
    rst = 1'b1;
    step();
    check_quiet("rst_mid");
    rst = 1'b0;
    step();
    check_quiet("rst_after");
    check("rst_nwr", wr_q.size(), 5);
    for (int k = 0; k < 5 && k < wr_q.size(); k++) begin
      check($sformatf("rst_a%0d", k), wr_q[k].addr, ew[k].addr);
      check($sformatf("rst_d%0d", k), wr_q[k].data, ew[k].data);
    end
    run_session("after_rst", build(1, 0), 30);

    for (int s = 0; s < 8; s++) begin
      run_session($sformatf("rnd%0d", s), build($urandom_range(1, 24), 5), 30);
    end

`ifdef PROG_LOADER_CKSUM_EN
    b = {8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h01};
    run_session("ck_good", b, 0);
    check("ck_good_err", bus.ERR, 0);
    b = {8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'hFF};
    run_session("ck_bad", b, 0);
    check("ck_bad_err", bus.ERR, 1);
    check("ck_bad_w0", (wr_q.size() > 0) ? wr_q[0].data : -1, 32'h10203);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
